vga_timing_ctrl: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Drives the DE/x_pixel/y_pixel inputs of the pattern generators (color bar and successors) and the h_sync/v_sync pins.
- Owns the pixel-rate enable, the horizontal/vertical counters and the phase sequencing. Pixel datapaths stay purely combinational on its outputs.

---
 rtl/vga_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing: pixel-rate enable, h/v counters, phase decode and sync/DE outputs.
// Optional completed-frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pclk_tick,
    output logic        h_sync,
    output logic        v_sync,
    output logic        DE,
    output logic [9:0]  x_pixel,
    output logic [9:0]  y_pixel,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [1:0] PH_VISIBLE = 2'd0;
    localparam logic [1:0] PH_FP      = 2'd1;
    localparam logic [1:0] PH_SYNC    = 2'd2;
    localparam logic [1:0] PH_BP      = 2'd3;

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [1:0]    h_phase;
    logic [1:0]    v_phase;
    logic          at_origin;

    assign pclk_tick = (div_cnt == DIV_LAST);
    assign at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Phase is a pure function of the counter, so it can never drift from it.
    always_comb begin
        h_phase = PH_BP;
        if (h_cnt < H_FP_START) begin
            h_phase = PH_VISIBLE;
        end else if (h_cnt < H_SYNC_START) begin
            h_phase = PH_FP;
        end else if (h_cnt < H_BP_START) begin
            h_phase = PH_SYNC;
        end
    end

    always_comb begin
        v_phase = PH_BP;
        if (v_cnt < V_FP_START) begin
            v_phase = PH_VISIBLE;
        end else if (v_cnt < V_SYNC_START) begin
            v_phase = PH_FP;
        end else if (v_cnt < V_BP_START) begin
            v_phase = PH_SYNC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (pclk_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pclk_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Outputs capture the pixel the counters point at on the tick edge, so the
    // first tick after reset presents (0,0) and each value holds for CLK_DIV clks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            DE          <= 1'b0;
            x_pixel     <= '0;
            y_pixel     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pclk_tick && at_origin;
            if (pclk_tick) begin
                h_sync  <= (h_phase != PH_SYNC);
                v_sync  <= (v_phase != PH_SYNC);
                DE      <= (h_phase == PH_VISIBLE) && (v_phase == PH_VISIBLE);
                x_pixel <= h_cnt;
                y_pixel <= v_cnt;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic first_seen;

    // The first frame_start after reset opens frame 0 rather than completing one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_seen <= 1'b0;
            frame_cnt  <= '0;
        end else if (pclk_tick && at_origin) begin
            if (first_seen) begin
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                first_seen <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default horizontal timing with a shortened
// vertical raster (12 lines) so a full frame fits in a short run.
module tb_vga_timing_ctrl;

    localparam int unsigned CD = 4;
    localparam int unsigned HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int unsigned VV = 6, VF = 2, VS = 2, VB = 2;
    localparam int unsigned HT = HV + HF + HS + HB;  // 800
    localparam int unsigned VT = VV + VF + VS + VB;  // 12
    localparam int unsigned FRAME_PIX = HT * VT;     // 9600

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pclk_tick, h_sync, v_sync, DE, frame_start;
    logic [9:0] x_pixel, y_pixel;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int unsigned cyc = 0;
    int passes = 0;
    int checks = 0;

    vga_timing_ctrl #(
        .CLK_DIV  (CD),
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pclk_tick  (pclk_tick),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .DE         (DE),
        .x_pixel    (x_pixel),
        .y_pixel    (y_pixel),
        .frame_start(frame_start)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance to the negedge just after the next pixel-tick edge; gap = clks between ticks.
    task automatic next_pixel(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!pclk_tick && gap < 4 * CD);
        if (!pclk_tick) chk("tick_timeout", 0, 1);
        @(negedge clk);
        gap++;
    endtask

    initial begin
        int gap, ex, ey;
        int bad_gap, bad_xy, bad_de, bad_hs, bad_vs, bad_fs;
        int de_total, de_line1, hs_line1, hs_first, vs_low, de_out;
        int unsigned t0, t1;
        bit found;

        bad_gap = 0; bad_xy = 0; bad_de = 0; bad_hs = 0; bad_vs = 0; bad_fs = 0;
        de_total = 0; de_line1 = 0; hs_line1 = 0; hs_first = -1; vs_low = 0; de_out = 0;
        t0 = 0; t1 = 0;

        repeat (3) @(negedge clk);
        chk("rst_pclk_tick", pclk_tick, 0);
        chk("rst_h_sync", h_sync, 1);
        chk("rst_v_sync", v_sync, 1);
        chk("rst_de", DE, 0);
        chk("rst_x", x_pixel, 0);
        chk("rst_y", y_pixel, 0);
        chk("rst_frame_start", frame_start, 0);

        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("pre_de", DE, 0);
            chk("pre_h_sync", h_sync, 1);
            chk("pre_x", x_pixel, 0);
            chk("pre_tick", pclk_tick, (i == 3) ? 1 : 0);
        end
        @(negedge clk);
        t0 = cyc;
        chk("first_de", DE, 1);
        chk("first_frame_start", frame_start, 1);
        chk("first_x", x_pixel, 0);
        chk("first_y", y_pixel, 0);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_first", frame_cnt, 0);
`endif

        // One full frame; pixel p is expected at (p % HT, (p / HT) % VT).
        for (int p = 1; p <= FRAME_PIX; p++) begin
            next_pixel(gap);
            if (gap != CD) bad_gap++;
            ex = p % HT;
            ey = (p / HT) % VT;
            if (x_pixel !== 10'(ex) || y_pixel !== 10'(ey)) bad_xy++;
            if (DE !== ((ex < HV) && (ey < VV))) bad_de++;
            if (h_sync !== !((ex >= HV + HF) && (ex < HV + HF + HS))) bad_hs++;
            if (v_sync !== !((ey >= VV + VF) && (ey < VV + VF + VS))) bad_vs++;
            if (frame_start !== (p == FRAME_PIX)) bad_fs++;
            if (DE === 1'b1) de_total++;
            if (DE === 1'b1 && y_pixel >= 10'(VV)) de_out++;
            if (v_sync === 1'b0) vs_low++;
            if (ey == 1) begin
                if (DE === 1'b1) de_line1++;
                if (h_sync === 1'b0) begin
                    hs_line1++;
                    if (hs_first < 0) hs_first = int'(x_pixel);
                end
            end
            if (p == HT - 1) begin
                chk("line_end_x", x_pixel, HT - 1);
                chk("line_end_y", y_pixel, 0);
            end
            if (p == HT) begin
                chk("wrap_x", x_pixel, 0);
                chk("wrap_y", y_pixel, 1);
            end
            if (p == FRAME_PIX) t1 = cyc;
        end
        chk("tick_spacing_errors", bad_gap, 0);
        chk("xy_errors", bad_xy, 0);
        chk("de_errors", bad_de, 0);
        chk("h_sync_errors", bad_hs, 0);
        chk("v_sync_errors", bad_vs, 0);
        chk("frame_start_errors", bad_fs, 0);
        chk("de_ticks_frame", de_total, HV * VV);
        chk("de_ticks_line", de_line1, HV);
        chk("h_sync_low_ticks", hs_line1, HS);
        chk("h_sync_first_x", hs_first, HV + HF);
        chk("v_sync_low_ticks", vs_low, VS * HT);
        chk("de_outside_visible", de_out, 0);
        chk("frame_period_clks", t1 - t0, FRAME_PIX * CD);
        chk("frame_start_second", frame_start, 1);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_second", frame_cnt, 1);
`endif
        @(negedge clk);
        chk("frame_start_one_clk", frame_start, 0);

        // Reset mid-frame at (300,3).
        found = 1'b0;
        for (int p = 0; p < 2 * FRAME_PIX && !found; p++) begin
            next_pixel(gap);
            if (x_pixel == 10'd300 && y_pixel == 10'd3) found = 1'b1;
        end
        chk("mid_found", found, 1);
        chk("mid_de_before", DE, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_de", DE, 0);
        chk("async_x", x_pixel, 0);
        chk("async_y", y_pixel, 0);
        chk("async_h_sync", h_sync, 1);
        chk("async_v_sync", v_sync, 1);
        chk("async_pclk_tick", pclk_tick, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (CD) @(negedge clk);
        chk("restart_x", x_pixel, 0);
        chk("restart_y", y_pixel, 0);
        chk("restart_de", DE, 1);
        chk("restart_frame_start", frame_start, 1);
`ifdef VGA_FRAME_CNT_EN
        chk("restart_frame_cnt", frame_cnt, 0);
`endif
        next_pixel(gap);
        chk("restart_next_x", x_pixel, 1);
        chk("restart_next_gap", gap, CD);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
